i2s_rx: RTL and testbench
=========================

# i2s_rx

Receive-side I2S deserializer for the audio codec ADC path. Oversamples the codec's `ac_bclk`, `ac_lrclk` and `ac_adc_sdata` in the system clock domain and recovers 24-bit left/right sample pairs. Each pair is presented on a valid/ready interface to the mixer/main module. It is the counterpart of the existing transmit path, which serializes `out_audioL`/`out_audioR` onto `ac_dac_sdata`.

## Interface
Parameters:
- `WIDTH`, 24: sample bits captured per channel, MSB first.
- `SLOT`, 32: BCLK periods per channel slot. Must satisfy `SLOT >= WIDTH + 1`.

Ports:
- `clk` in 1: system clock, 100 MHz. Must be at least 4× the BCLK frequency.
- `rst_n` in 1: asynchronous, active-low reset.
- `bclk` in 1: codec serial bit clock. Asynchronous to `clk`.
- `lrclk` in 1: codec word clock. 0 = left slot, 1 = right slot.
- `sdata` in 1: codec serial data (`ac_adc_sdata`).
- `out_l` out WIDTH: left sample, two's complement.
- `out_r` out WIDTH: right sample, two's complement.
- `out_valid` out 1: a sample pair is held.
- `out_ready` in 1: consumer accepts the pair.
- `overrun` out 1: one-cycle pulse when an unconsumed pair is overwritten.
- `frame_err` out 1: one-cycle pulse when a slot ends before `WIDTH` bits were captured.
- `overrun_cnt` out 8: saturating count of overruns.

## Operation
- **Synchronization.** `bclk`, `lrclk` and `sdata` each pass through an identical 2-flop synchronizer. A third register on `bclk` detects rising edges (`rise` = sync_bclk & ~bclk_d). All protocol actions below occur only on cycles where `rise` = 1, using the synchronized `lrclk` and `sdata`.
- **Slot tracking.**
  - `lr_prev` holds `lrclk` from the previous rise.
  - A rise where `lrclk != lr_prev` is the delay bit. Its data is discarded and `bit_cnt` is cleared to 0.
  - On every other rise with `bit_cnt < WIDTH`: shift `sdata` into the shift register LSB and increment `bit_cnt`.
  - When the increment makes `bit_cnt` equal to `WIDTH`, latch the full word into `hold_l` (if `lrclk`=0) or `hold_r` (if `lrclk`=1).
  - Rises with `bit_cnt == WIDTH` are ignored; the counter saturates.
- **State machine.**
  - ALIGN (reset state): wait for a 1→0 transition of `lrclk` at a rise, then go to LEFT. All data before that transition is discarded.
  - LEFT: on the left word's capture, set `have_l`. On a 0→1 transition, go to RIGHT.
  - RIGHT: on the right word's capture, if `have_l` = 1, perform a pair-complete, then clear `have_l`. On a 1→0 transition, go to LEFT.
- **Short slot.** If a transition occurs while `bit_cnt` is in 1..WIDTH-1:
  - pulse `frame_err`;
  - drop the partial word;
  - clear `have_l`;
  - proceed with the new slot normally.
  - A transition with `bit_cnt` = 0 (two consecutive transitions) is also a short slot.
- **Pair-complete.** Load `out_l` ← `hold_l` and `out_r` ← right word, and set `out_valid`.
- **Handshake.**
  - A transfer occurs on a cycle with `out_valid & out_ready`; `out_valid` clears on the next edge unless a pair-complete happens in the same cycle.
  - Pair-complete with `out_valid`=1 and `out_ready`=0: overwrite `out_l`/`out_r` with the new pair, pulse `overrun`, and increment `overrun_cnt` (saturates at 255).
  - Pair-complete and transfer in the same cycle: the new pair loads, `out_valid` stays 1, no overrun.
  - `out_l`/`out_r` stay stable while `out_valid`=1 and no pair-complete occurs.

## Timing
- **Reset values.** When `rst_n` is low, all of the following clear immediately, regardless of `clk`:
  - `out_l`, `out_r`, `overrun_cnt` = 0;
  - `out_valid`, `overrun`, `frame_err` = 0;
  - state = ALIGN; `bit_cnt`, `have_l` and synchronizers cleared.
- **Reset deassertion.** After reset deasserts mid-frame, the block realigns on the next left-slot start. No partial pair is emitted.
- **Latency.** Pin-level `bclk` rising edge of the right word's LSB → `out_valid` high: exactly 4 `clk` edges (2 sync, 1 edge detect, 1 output register). `frame_err` and `overrun` follow the same latency from their triggering BCLK edge.
- **Output timing.** All outputs are registered. `out_valid` may assert back-to-back with a transfer in the same cycle.
- **Pair rate.** At most one pair-complete per `2*SLOT` BCLK periods.

## Test plan
- **Basic capture.** Reset, then drive a 3.125 MHz BCLK I2S stream with L=24'h123456 and R=24'hFEDCBA, SLOT=32, `out_ready`=1. Required:
  - no output for the partial frame before the first left slot;
  - `out_valid` asserts 4 clocks after the right LSB rise;
  - `out_l`=123456, `out_r`=FEDCBA.
- **Overrun.** Hold `out_ready`=0 across two frames (pairs 000001/000002, then 000003/000004). Required:
  - second pair-complete pulses `overrun` once;
  - `overrun_cnt`=1;
  - outputs are 000003/000004;
  - `out_valid` stays 1.
- **Simultaneous transfer.** Assert `out_ready` exactly on the pair-complete cycle of the next frame. Required: no `overrun`, `out_valid` remains 1, new pair presented.
- **Short slot.** Toggle `lrclk` after 10 bits of the left slot. Required:
  - `frame_err` pulses once;
  - no pair emitted for that frame;
  - the next full frame is captured correctly.
- **Reset mid-operation.** Assert `rst_n`=0 mid-right-slot while `out_valid`=1. Required:
  - all outputs 0 immediately;
  - after release, the first pair appears only after a full left+right frame following a 1→0 `lrclk` edge.
- **Counter saturation.** Force 300 overruns. Required: `overrun_cnt`=255, and `overrun` still pulses on each event.

Source files
------------

// File: rtl/i2s_rx.sv
// Purpose : I2S receive deserializer; oversamples bclk/lrclk/sdata in the clk domain and
//           recovers WIDTH-bit left/right sample pairs.
// Latency : 4 clk edges from the pin-level bclk rise of the right LSB to out_valid.
// Backpr. : a single output slot. A new pair overwrites an unconsumed pair and pulses overrun.
//
// Ports:
//   clk, rst_n         system clock, async active-low reset
//   bclk, lrclk, sdata codec serial interface, asynchronous to clk
//   out_l, out_r       sample pair, two's complement
//   out_valid          pair held; transfers when out_ready is high
//   overrun            one-cycle pulse when a held pair is overwritten
//   frame_err          one-cycle pulse when a slot ends before WIDTH bits were captured
//   overrun_cnt        saturating count of overruns
module i2s_rx #(
   parameter int WIDTH = 24,
   parameter int SLOT  = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bclk,
   input  logic             lrclk,
   input  logic             sdata,
   output logic [WIDTH-1:0] out_l,
   output logic [WIDTH-1:0] out_r,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             overrun,
   output logic             frame_err,
   output logic [7:0]       overrun_cnt
);

   // The counter only has to reach WIDTH, and WIDTH < SLOT, so SLOT sizes it.
   localparam int CW = $clog2(SLOT);
   localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {ALIGN, LEFT, RIGHT} state_t;

   logic [1:0]       bclk_sync, lr_sync, sd_sync;
   logic             bclk_d, rise_r, lr_r, sd_r, lr_prev;
   logic [CW-1:0]    bit_cnt;
   logic [WIDTH-2:0] shreg;
   logic [WIDTH-1:0] hold_l, word;
   logic             have_l;
   logic             trans, cap, word_done;
   logic             short_slot, pair_cmp, set_l, clr_l;
   state_t           state, state_nxt;

   // Synchronizers, edge detect, and one pipeline stage that aligns lrclk/sdata with the
   // registered rise strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bclk_sync <= '0;
         lr_sync   <= '0;
         sd_sync   <= '0;
         bclk_d    <= 1'b0;
         rise_r    <= 1'b0;
         lr_r      <= 1'b0;
         sd_r      <= 1'b0;
      end else begin
         bclk_sync <= {bclk_sync[0], bclk};
         lr_sync   <= {lr_sync[0], lrclk};
         sd_sync   <= {sd_sync[0], sdata};
         bclk_d    <= bclk_sync[1];
         rise_r    <= bclk_sync[1] & ~bclk_d;
         lr_r      <= lr_sync[1];
         sd_r      <= sd_sync[1];
      end
   end

   // A change of lrclk marks the delay bit of a new slot; it carries no data.
   assign trans     = rise_r & (lr_r != lr_prev);
   assign cap       = rise_r & ~trans & (bit_cnt < CNT_FULL);
   assign word_done = cap & (bit_cnt == CNT_LAST);
   assign word      = {shreg, sd_r};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ALIGN;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      short_slot = 1'b0;
      pair_cmp   = 1'b0;
      set_l      = 1'b0;
      clr_l      = 1'b0;
      case (state)
         ALIGN: begin
            // Only a right-to-left change starts a frame; everything earlier is dropped.
            if (trans && !lr_r) state_nxt = LEFT;
         end
         LEFT: begin
            if (word_done) set_l = 1'b1;
            if (trans) begin
               if (bit_cnt != CNT_FULL) begin
                  short_slot = 1'b1;
                  clr_l      = 1'b1;
               end
               if (lr_r) state_nxt = RIGHT;
            end
         end
         RIGHT: begin
            if (word_done) begin
               pair_cmp = have_l;
               clr_l    = 1'b1;
            end
            if (trans) begin
               if (bit_cnt != CNT_FULL) begin
                  short_slot = 1'b1;
                  clr_l      = 1'b1;
               end
               if (!lr_r) state_nxt = LEFT;
            end
         end
         default: state_nxt = ALIGN;
      endcase
   end

   // Slot tracking: bit counter, shift register, left-word hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lr_prev <= 1'b0;
         bit_cnt <= '0;
         shreg   <= '0;
         hold_l  <= '0;
         have_l  <= 1'b0;
      end else begin
         if (rise_r) lr_prev <= lr_r;
         if (trans) begin
            bit_cnt <= '0;
         end else if (cap) begin
            bit_cnt <= bit_cnt + 1'b1;
            shreg   <= word[WIDTH-2:0];
         end
         if (word_done && !lr_r) hold_l <= word;
         if (clr_l)      have_l <= 1'b0;
         else if (set_l) have_l <= 1'b1;
      end
   end

   // Output register. The right word goes straight to out_r, so no right hold is needed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_l       <= '0;
         out_r       <= '0;
         out_valid   <= 1'b0;
         overrun     <= 1'b0;
         frame_err   <= 1'b0;
         overrun_cnt <= '0;
      end else begin
         overrun   <= pair_cmp & out_valid & ~out_ready;
         frame_err <= short_slot;
         if (pair_cmp) begin
            out_l     <= hold_l;
            out_r     <= word;
            out_valid <= 1'b1;
            if (out_valid && !out_ready && overrun_cnt != 8'hFF)
               overrun_cnt <= overrun_cnt + 8'd1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_i2s_rx.sv
module tb_i2s_rx;
   localparam int W = 24;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         bclk = 1'b1;
   logic         lrclk = 1'b0;
   logic         sdata = 1'b0;
   logic         out_ready = 1'b1;
   logic [W-1:0] out_l, out_r;
   logic         out_valid, overrun, frame_err;
   logic [7:0]   overrun_cnt;

   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;
   int ov_seen = 0;
   int fe_seen = 0;
   int hb = 16;          // half bclk period in clk cycles
   int ov0, fe0;
   logic [2*W-1:0] exp_q[$];
   logic [2*W-1:0] mon_e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   i2s_rx #(.WIDTH(W), .SLOT(32)) dut (
      .clk(clk), .rst_n(rst_n), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
      .out_l(out_l), .out_r(out_r), .out_valid(out_valid), .out_ready(out_ready),
      .overrun(overrun), .frame_err(frame_err), .overrun_cnt(overrun_cnt)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", nm, act, req);
      end
   endtask

   // Scoreboard monitor: every transfer pops one expected pair.
   always @(negedge clk) begin
      if (rst_n) begin
         if (overrun)   ov_seen++;
         if (frame_err) fe_seen++;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_pair: got %h/%h, required no pair", out_l, out_r);
            end else begin
               mon_e = exp_q.pop_front();
               check("pair_l", 32'(out_l), 32'(mon_e[2*W-1:W]));
               check("pair_r", 32'(out_r), 32'(mon_e[W-1:0]));
            end
         end
      end
   end

   // One bclk period: data changes on the falling edge, sampled on the rising edge.
   task automatic drive_bit(input logic lr, input logic d);
      repeat (hb) @(posedge clk);
      #2;
      bclk = 1'b0; lrclk = lr; sdata = d;
      repeat (hb) @(posedge clk);
      #2;
      bclk = 1'b1;
   endtask

   task automatic send_slot(input logic lr, input logic [W-1:0] w, input int ndata, input int npad);
      drive_bit(lr, 1'b0);
      for (int i = 0; i < ndata; i++) drive_bit(lr, w[W-1-i]);
      for (int i = 0; i < npad; i++) drive_bit(lr, 1'b0);
   endtask

   task automatic frame(input logic [W-1:0] l, input logic [W-1:0] r, input int pad,
                        input bit exp, input bit chk_lat, input bit rdy_pulse);
      send_slot(1'b0, l, W, pad);
      drive_bit(1'b1, 1'b0);
      for (int i = 0; i < W; i++) drive_bit(1'b1, r[W-1-i]);
      // Now 2 ns after the clk edge that precedes the right LSB rise.
      if (exp) exp_q.push_back({l, r});
      if (chk_lat) begin
         repeat (3) @(posedge clk);
         #1 check("lat_edge3_low", 32'(out_valid), 32'd0);
         @(posedge clk);
         #1 check("lat_edge4_high", 32'(out_valid), 32'd1);
      end
      if (rdy_pulse) begin
         repeat (3) @(posedge clk);
         #2 out_ready = 1'b1;
         @(posedge clk);
         #2 out_ready = 1'b0;
         check("simul_overrun", 32'(overrun), 32'd0);
         check("simul_valid", 32'(out_valid), 32'd1);
         check("simul_l", 32'(out_l), 32'(l));
         check("simul_r", 32'(out_r), 32'(r));
      end
      for (int i = 0; i < pad; i++) drive_bit(1'b1, 1'b0);
   endtask

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_l", 32'(out_l), 32'd0);
      check("rst_r", 32'(out_r), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      check("rst_cnt", 32'(overrun_cnt), 32'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;

      // Basic capture at 3.125 MHz bclk: partial frame first, which must be dropped
      hb = 16;
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) drive_bit(1'b0, i[0]);
      send_slot(1'b1, 24'hAAAAAA, W, 7);
      frame(24'h123456, 24'hFEDCBA, 7, 1'b1, 1'b1, 1'b0);
      hb = 2;
      frame(24'h800000, 24'h7FFFFF, 7, 1'b1, 1'b1, 1'b0);
      repeat (10) @(posedge clk);
      check("basic_drained", 32'(exp_q.size()), 32'd0);
      check("basic_no_ferr", 32'(fe_seen), 32'd0);
      check("basic_no_ovr", 32'(ov_seen), 32'd0);

      // Overrun: two frames with no consumer
      out_ready = 1'b0;
      ov0 = ov_seen;
      frame(24'h000001, 24'h000002, 7, 1'b0, 1'b0, 1'b0);
      frame(24'h000003, 24'h000004, 7, 1'b1, 1'b0, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      check("ovr_pulses", 32'(ov_seen - ov0), 32'd1);
      check("ovr_cnt", 32'(overrun_cnt), 32'd1);
      check("ovr_valid", 32'(out_valid), 32'd1);
      check("ovr_l", 32'(out_l), 32'h000003);
      check("ovr_r", 32'(out_r), 32'h000004);

      // Transfer on the same cycle as the next pair-complete
      frame(24'h000005, 24'h000006, 7, 1'b1, 1'b0, 1'b1);
      repeat (10) @(posedge clk);
      #1;
      check("simul_no_new_ovr", 32'(ov_seen - ov0), 32'd1);
      check("simul_cnt", 32'(overrun_cnt), 32'd1);
      out_ready = 1'b1;
      repeat (5) @(posedge clk);
      check("simul_drained", 32'(exp_q.size()), 32'd0);

      // Short left slot: lrclk toggles after 10 bits
      fe0 = fe_seen;
      send_slot(1'b0, 24'hABCDEF, 10, 0);
      send_slot(1'b1, 24'h5A5A5A, W, 7);
      frame(24'h654321, 24'h0F0F0F, 7, 1'b1, 1'b0, 1'b0);
      repeat (10) @(posedge clk);
      check("short_ferr", 32'(fe_seen - fe0), 32'd1);
      check("short_drained", 32'(exp_q.size()), 32'd0);

      // Reset in the middle of a right slot while a pair is held
      out_ready = 1'b0;
      frame(24'h000007, 24'h000008, 7, 1'b0, 1'b0, 1'b0);
      send_slot(1'b0, 24'h999999, W, 7);
      drive_bit(1'b1, 1'b0);
      for (int i = 0; i < 12; i++) drive_bit(1'b1, i[0]);
      check("prerst_valid", 32'(out_valid), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_valid", 32'(out_valid), 32'd0);
      check("midrst_l", 32'(out_l), 32'd0);
      check("midrst_r", 32'(out_r), 32'd0);
      check("midrst_cnt", 32'(overrun_cnt), 32'd0);
      repeat (3) @(posedge clk);
      #2;
      out_ready = 1'b1;
      rst_n = 1'b1;
      fe0 = fe_seen;
      for (int i = 0; i < 12; i++) drive_bit(1'b1, i[1]);
      for (int i = 0; i < 7; i++) drive_bit(1'b1, 1'b0);
      frame(24'h111111, 24'h222222, 7, 1'b1, 1'b0, 1'b0);
      repeat (10) @(posedge clk);
      check("postrst_drained", 32'(exp_q.size()), 32'd0);
      check("postrst_no_ferr", 32'(fe_seen - fe0), 32'd0);

      // Counter saturation: 301 back-to-back frames, 300 of them overwrite
      out_ready = 1'b0;
      ov0 = ov_seen;
      for (int i = 0; i < 301; i++)
         frame(24'(i), 24'(i + 4096), 0, (i == 300), 1'b0, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      check("sat_pulses", 32'(ov_seen - ov0), 32'd300);
      check("sat_cnt", 32'(overrun_cnt), 32'd255);
      check("sat_valid", 32'(out_valid), 32'd1);
      check("sat_l", 32'(out_l), 32'd300);
      out_ready = 1'b1;
      repeat (5) @(posedge clk);
      check("sat_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
